// File: rtl/sigmoid_arbiter.sv
// Round-robin front end that shares one fixed-latency sigmoid pipeline among N_REQ requesters.
// Results are tagged with the requester ID and returned in accept order through a response FIFO.
module sigmoid_arbiter #(
  parameter int N_REQ      = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 sig_valid_in,
  output logic [15:0]          sig_data_in,
  input  logic                 sig_valid_out,
  input  logic [15:0]          sig_data_out,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic [15:0]          resp_data,
  input  logic                 resp_ready,
  output logic                 busy,
  output logic                 err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 2;

  logic                 issue_v_q;
  logic [15:0]          issue_data_q;
  logic [ID_W-1:0]      issue_id_q;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      tag_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     tag_wr_q, tag_rd_q;
  logic [CNT_W-1:0]     tag_cnt_q, tag_cnt_d;
  logic [ID_W+15:0]     resp_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     resp_wr_q, resp_rd_q;
  logic [CNT_W-1:0]     resp_cnt_q, resp_cnt_d;
  logic                 err_q;

  logic                 grant_found;
  logic [ID_W-1:0]      grant_idx;
  logic [ID_W:0]        cand;
  logic [SUM_W-1:0]     inflight;
  logic                 credit_ok, accept;
  logic                 tag_push, tag_pop, err_set;
  logic                 resp_push, resp_pop, resp_full;

  // Every accepted operand is counted exactly once: in the issue register, then as a tag, then as a response.
  assign inflight  = SUM_W'(issue_v_q) + SUM_W'(tag_cnt_q) + SUM_W'(resp_cnt_q);
  assign credit_ok = inflight < SUM_W'(FIFO_DEPTH);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  // rst_n gates the grant so req_ready drops the moment reset is asserted.
  assign accept = rst_n & grant_found & credit_ok;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      if (grant_idx == ID_W'(N_REQ - 1)) rr_ptr_d = '0;
      else                               rr_ptr_d = grant_idx + ID_W'(1);
    end
  end

  assign tag_push  = issue_v_q;
  assign tag_pop   = sig_valid_out & (tag_cnt_q != '0);
  assign err_set   = sig_valid_out & (tag_cnt_q == '0);
  assign resp_push = tag_pop;
  assign resp_valid = resp_cnt_q != '0;
  assign resp_pop  = resp_valid & resp_ready;
  assign resp_full = resp_cnt_q == CNT_W'(FIFO_DEPTH);

  always_comb begin
    tag_cnt_d = tag_cnt_q;
    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + CNT_W'(1);
      2'b01:   tag_cnt_d = tag_cnt_q - CNT_W'(1);
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  always_comb begin
    resp_cnt_d = resp_cnt_q;
    case ({resp_push, resp_pop})
      2'b10:   resp_cnt_d = resp_cnt_q + CNT_W'(1);
      2'b01:   resp_cnt_d = resp_cnt_q - CNT_W'(1);
      default: resp_cnt_d = resp_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_v_q    <= 1'b0;
      issue_data_q <= '0;
      issue_id_q   <= '0;
      rr_ptr_q     <= '0;
      tag_wr_q     <= '0;
      tag_rd_q     <= '0;
      tag_cnt_q    <= '0;
      resp_wr_q    <= '0;
      resp_rd_q    <= '0;
      resp_cnt_q   <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tag_mem_q[i]  <= '0;
        resp_mem_q[i] <= '0;
      end
    end else begin
      issue_v_q <= accept;
      if (accept) begin
        issue_data_q <= req_data[16*grant_idx +: 16];
        issue_id_q   <= grant_idx;
      end
      rr_ptr_q <= rr_ptr_d;
      if (tag_push) begin
        tag_mem_q[tag_wr_q] <= issue_id_q;
        tag_wr_q            <= tag_wr_q + PTR_W'(1);
      end
      if (tag_pop) tag_rd_q <= tag_rd_q + PTR_W'(1);
      tag_cnt_q <= tag_cnt_d;
      if (resp_push) begin
        resp_mem_q[resp_wr_q] <= {tag_mem_q[tag_rd_q], sig_data_out};
        resp_wr_q             <= resp_wr_q + PTR_W'(1);
      end
      if (resp_pop) resp_rd_q <= resp_rd_q + PTR_W'(1);
      resp_cnt_q <= resp_cnt_d;
      if (err_set) err_q <= 1'b1;
    end
  end

  assign sig_valid_in = issue_v_q;
  assign sig_data_in  = issue_data_q;
  assign resp_id      = resp_mem_q[resp_rd_q][ID_W+15:16];
  assign resp_data    = resp_mem_q[resp_rd_q][15:0];
  assign busy         = issue_v_q | (tag_cnt_q != '0) | resp_valid;
  assign err          = err_q;

  // Credit admission must make a push into a full response FIFO impossible.
  assert property (@(posedge clk) disable iff (!rst_n) !(resp_push && resp_full));

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed bench for sigmoid_arbiter with a latency-5 sigmoid stand-in and a response scoreboard.
module tb_sigmoid_arbiter;
  localparam int N_REQ      = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int ID_W       = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                sig_valid_in;
  logic [15:0]         sig_data_in;
  logic                sig_valid_out;
  logic [15:0]         sig_data_out;
  logic                resp_valid;
  logic [ID_W-1:0]     resp_id;
  logic [15:0]         resp_data;
  logic                resp_ready;
  logic                busy;
  logic                err;
  logic                force_svo;

  int tests = 0;
  int fails = 0;
  logic [ID_W+15:0] exp_q[$];

  sigmoid_arbiter #(.N_REQ(N_REQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .sig_valid_in(sig_valid_in), .sig_data_in(sig_data_in),
    .sig_valid_out(sig_valid_out), .sig_data_out(sig_data_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_ready(resp_ready), .busy(busy), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- sigmoid stand-in (latency 5, sync reset from rst_n) ----------------
  function automatic logic [15:0] sig_f(input logic [15:0] x);
    case (x)
      16'h3F80: sig_f = 16'h3F3B;
      16'h0000: sig_f = 16'h3F00;
      16'hBF80: sig_f = 16'h3E8A;
      default:  sig_f = x ^ 16'h1234;
    endcase
  endfunction

  logic [4:0]  pv;
  logic [15:0] pd [5];
  always @(posedge clk) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < 5; i++) pd[i] <= '0;
    end else begin
      pv    <= {pv[3:0], sig_valid_in};
      pd[0] <= sig_f(sig_data_in);
      for (int i = 1; i < 5; i++) pd[i] <= pd[i-1];
    end
  end
  assign sig_valid_out = pv[4] | force_svo;
  assign sig_data_out  = pd[4];

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next_drive();
  endtask

  task automatic set_all(input logic [15:0] base);
    for (int i = 0; i < N_REQ; i++) req_data[16*i +: 16] = base + 16'(i);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor: reference grant model + response compare ----------------
  int m_ptr = 0;
  int m_cnt = 0;
  always @(negedge clk) begin
    logic [N_REQ-1:0] eg;
    logic             found;
    int               gi;
    int               c;
    logic [ID_W+15:0] e;
    if (!rst_n) begin
      exp_q.delete();
      m_ptr = 0;
      m_cnt = 0;
      check("ready_in_reset", 32'(req_ready), 32'h0);
    end else begin
      eg = '0;
      found = 1'b0;
      gi = 0;
      if (m_cnt < FIFO_DEPTH) begin
        for (int k = 0; k < N_REQ; k++) begin
          c = (m_ptr + k) % N_REQ;
          if (!found && req_valid[c]) begin
            found = 1'b1;
            gi = c;
          end
        end
      end
      if (found) eg[gi] = 1'b1;
      check("grant", 32'(req_ready), 32'(eg));
      if (found) begin
        exp_q.push_back({ID_W'(gi), sig_f(req_data[16*gi +: 16])});
        m_ptr = (gi + 1) % N_REQ;
        m_cnt++;
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL resp_unexpected: got id %0d data %0h expected no response", resp_id, resp_data);
        end else begin
          e = exp_q.pop_front();
          check("resp", 32'({resp_id, resp_data}), 32'(e));
          m_cnt--;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int acc;
  logic [N_REQ-1:0] exp_g;

  initial begin
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b1;
    force_svo  = 1'b0;
    rst_n      = 1'b0;
    idle(3);
    check("rst_sig_valid_in", 32'(sig_valid_in), 32'h0);
    check("rst_sig_data_in", 32'(sig_data_in), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    check("rst_resp_data", 32'(resp_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Test 1: single request from requester 2, latency profile
    req_valid = 4'b0100;
    req_data[32 +: 16] = 16'h3F80;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h4);
    next_drive();
    req_valid = '0;
    @(negedge clk);
    check("t1_sig_valid_in", 32'(sig_valid_in), 32'h1);
    check("t1_sig_data_in", 32'(sig_data_in), 32'h3F80);
    repeat (5) @(negedge clk);
    check("t1_resp_early", 32'(resp_valid), 32'h0);
    @(negedge clk);
    check("t1_resp_valid", 32'(resp_valid), 32'h1);
    check("t1_resp_id", 32'(resp_id), 32'h2);
    check("t1_resp_data", 32'(resp_data), 32'h3F3B);
    @(negedge clk);
    check("t1_resp_popped", 32'(resp_valid), 32'h0);
    next_drive();

    // Test 2: 0x0000 from requester 0, 0xBF80 from requester 1
    req_valid = 4'b0001;
    req_data[0 +: 16] = 16'h0000;
    next_drive();
    req_valid = 4'b0010;
    req_data[16 +: 16] = 16'hBF80;
    next_drive();
    req_valid = '0;
    idle(12);

    // Test 3: all requesters valid, round-robin and gap-free responses
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 16; k++) begin
      set_all(16'h1000 + 16'(k * 16));
      @(negedge clk);
      exp_g = 4'b0001 << (k % 4);
      check("t3_grant", 32'(req_ready), 32'(exp_g));
      if (k >= 7) begin
        check("t3_nogap", 32'(resp_valid), 32'h1);
        check("t3_resp_id", 32'(resp_id), 32'((k - 7) % 4));
      end
      next_drive();
    end
    req_valid = '0;
    idle(12);

    // Test 4: consumer stalled -> credit limit, then drain and resume
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    acc = 0;
    for (int k = 0; k < 14; k++) begin
      set_all(16'hA000 + 16'(k * 16));
      @(negedge clk);
      if (req_ready != '0) acc++;
      next_drive();
    end
    @(negedge clk);
    check("t4_accepts", 32'(acc), 32'd8);
    check("t4_ready_blocked", 32'(req_ready), 32'h0);
    check("t4_busy", 32'(busy), 32'h1);
    check("t4_resp_valid", 32'(resp_valid), 32'h1);
    next_drive();
    resp_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      set_all(16'hB000 + 16'(k * 16));
      @(negedge clk);
      if (req_ready != '0) acc++;
      next_drive();
    end
    check("t4_resume", 32'(acc), 32'd3);
    req_valid = '0;
    idle(24);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_idle", 32'(busy), 32'h0);

    // Test 5: spurious sigmoid result -> sticky err, nothing queued
    force_svo = 1'b1;
    next_drive();
    force_svo = 1'b0;
    @(negedge clk);
    check("t5_err", 32'(err), 32'h1);
    check("t5_no_resp", 32'(resp_valid), 32'h0);
    idle(5);
    @(negedge clk);
    check("t5_err_sticky", 32'(err), 32'h1);
    check("t5_no_resp_later", 32'(resp_valid), 32'h0);
    check("t5_not_busy", 32'(busy), 32'h0);
    next_drive();

    // Test 6: async reset with operations in flight
    req_valid = 4'b1111;
    set_all(16'hC000);
    idle(3);
    req_valid = 4'b1111;
    check("t6_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t6_ready", 32'(req_ready), 32'h0);
    check("t6_sig_valid_in", 32'(sig_valid_in), 32'h0);
    check("t6_sig_data_in", 32'(sig_data_in), 32'h0);
    check("t6_resp_valid", 32'(resp_valid), 32'h0);
    check("t6_resp_id", 32'(resp_id), 32'h0);
    check("t6_resp_data", 32'(resp_data), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_err", 32'(err), 32'h0);
    idle(2);
    req_valid = 4'b1010;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_first_grant", 32'(req_ready), 32'h2);
    next_drive();
    req_valid = '0;
    idle(14);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
